// File: rtl/adpll_lock_seq.sv
// ADPLL bring-up sequencer: bus master on the ADPLL CPU port that programs the
// channel, enables the loop and polls lock/saturation with bounded retries.
module adpll_lock_seq #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned FCWW       = 26,
    parameter int unsigned A_SOFT_RST = 0,
    parameter int unsigned A_FCW      = 1,
    parameter int unsigned A_MODE     = 2,
    parameter int unsigned A_EN       = 3,
    parameter int unsigned A_LOCK     = 20,
    parameter int unsigned A_SAT      = 21,
    parameter int unsigned SETTLE     = 256,
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned RETRIES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [FCWW-1:0]   fcw_in,
    input  logic [1:0]        mode_in,
    output logic              sel,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       wdata,
    input  logic              ready,
    input  logic [31:0]       rdata,
    output logic              busy,
    output logic              locked,
    output logic              fail,
    output logic              sat_seen,
    output logic [1:0]        attempt
);

    localparam int unsigned WAIT_MAX = (SETTLE > POLL_GAP) ? SETTLE : POLL_GAP;
    localparam int unsigned CW = $clog2(WAIT_MAX) + 1;
    localparam int unsigned SW = $clog2(LOCK_CNT) + 1;
    localparam int unsigned RW = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(POLL_GAP - 1);
    localparam logic [SW-1:0] STREAK_FULL = SW'(LOCK_CNT);
    localparam logic [RW-1:0] ROUND_FULL  = RW'(TIMEOUT);
    localparam logic [RW-1:0] ROUND_LAST  = RW'(TIMEOUT - 1);
    localparam logic [1:0]    RETRY_MAX   = 2'(RETRIES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_SRST,
        S_W_FCW,
        S_W_MODE,
        S_W_EN,
        S_SETTLE,
        S_R_LOCK,
        S_R_SAT,
        S_GAP,
        S_W_DIS,
        S_ABORT_DIS
    } state_e;

    state_e              state_q, state_d;
    logic                sel_q, write_q;
    logic [ADDR_W-1:0]   address_q;
    logic [31:0]         wdata_q;
    logic                ph_q;
    logic                busy_q, locked_q, fail_q, sat_seen_q;
    logic [1:0]          attempt_q;
    logic [FCWW-1:0]     fcw_q;
    logic [1:0]          mode_q;
    logic [CW-1:0]       cnt_q;
    logic [SW-1:0]       streak_q;
    logic [RW-1:0]       round_q;
    logic                sat_q;
    logic                abort_pend_q;

    logic                abort_any;
    logic                bus_go_d;
    logic                bus_write_d;
    logic [ADDR_W-1:0]   bus_addr_d;
    logic [31:0]         bus_wdata_d;
    logic                unused_rdata;

    assign unused_rdata = ^rdata[31:1];
    assign abort_any    = abort_pend_q | abort;

    // ph_q marks the forced-idle cycle that closes every transaction; all
    // bus-state exits happen there so each access is exactly three cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = S_W_SRST;
            S_W_SRST:    if (ph_q) state_d = abort_any ? S_ABORT_DIS : S_W_FCW;
            S_W_FCW:     if (ph_q) state_d = abort_any ? S_ABORT_DIS : S_W_MODE;
            S_W_MODE:    if (ph_q) state_d = abort_any ? S_ABORT_DIS : S_W_EN;
            S_W_EN:      if (ph_q) state_d = abort_any ? S_ABORT_DIS : S_SETTLE;
            S_SETTLE: begin
                if (abort_any)                 state_d = S_ABORT_DIS;
                else if (cnt_q == SETTLE_LAST) state_d = S_R_LOCK;
            end
            S_R_LOCK:    if (ph_q) state_d = abort_any ? S_ABORT_DIS : S_R_SAT;
            S_R_SAT: begin
                if (ph_q) begin
                    if (abort_any)                    state_d = S_ABORT_DIS;
                    else if (sat_q)                   state_d = S_W_DIS;
                    else if (streak_q == STREAK_FULL) state_d = S_IDLE;
                    else if (round_q == ROUND_LAST)   state_d = S_W_DIS;
                    else                              state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (abort_any)              state_d = S_ABORT_DIS;
                else if (cnt_q == GAP_LAST) state_d = S_R_LOCK;
            end
            S_W_DIS: begin
                if (ph_q) begin
                    if (abort_any)                            state_d = S_ABORT_DIS;
                    else if (!sat_q && attempt_q < RETRY_MAX) state_d = S_W_SRST;
                    else                                      state_d = S_IDLE;
                end
            end
            S_ABORT_DIS: if (ph_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Bus request launched on entry to a bus state.
    always_comb begin
        bus_go_d    = (state_d != state_q);
        bus_write_d = 1'b1;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        case (state_d)
            S_W_SRST: begin
                bus_addr_d  = ADDR_W'(A_SOFT_RST);
                bus_wdata_d = 32'd1;
            end
            S_W_FCW: begin
                bus_addr_d  = ADDR_W'(A_FCW);
                bus_wdata_d = {{(32 - FCWW){1'b0}}, fcw_q};
            end
            S_W_MODE: begin
                bus_addr_d  = ADDR_W'(A_MODE);
                bus_wdata_d = {30'd0, mode_q};
            end
            S_W_EN: begin
                bus_addr_d  = ADDR_W'(A_EN);
                bus_wdata_d = 32'd1;
            end
            S_R_LOCK: begin
                bus_addr_d  = ADDR_W'(A_LOCK);
                bus_write_d = 1'b0;
            end
            S_R_SAT: begin
                bus_addr_d  = ADDR_W'(A_SAT);
                bus_write_d = 1'b0;
            end
            S_W_DIS, S_ABORT_DIS: bus_addr_d = ADDR_W'(A_EN);
            default: bus_go_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            ph_q         <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            sat_seen_q   <= 1'b0;
            attempt_q    <= '0;
            fcw_q        <= '0;
            mode_q       <= '0;
            cnt_q        <= '0;
            streak_q     <= '0;
            round_q      <= '0;
            sat_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (sel_q && ready) begin
                sel_q <= 1'b0;
                ph_q  <= 1'b1;
                if (state_q == S_R_LOCK) begin
                    if (rdata[0]) begin
                        if (streak_q != STREAK_FULL) streak_q <= streak_q + 1'b1;
                    end else begin
                        streak_q <= '0;
                    end
                end
                if (state_q == S_R_SAT) sat_q <= rdata[0];
            end else if (ph_q) begin
                ph_q <= 1'b0;
            end

            if (bus_go_d) begin
                sel_q     <= 1'b1;
                write_q   <= bus_write_d;
                address_q <= bus_addr_d;
                wdata_q   <= bus_wdata_d;
            end

            if (state_q != S_IDLE && abort) abort_pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fcw_q        <= fcw_in;
                        mode_q       <= mode_in;
                        locked_q     <= 1'b0;
                        fail_q       <= 1'b0;
                        sat_seen_q   <= 1'b0;
                        attempt_q    <= '0;
                        busy_q       <= 1'b1;
                        abort_pend_q <= 1'b0;
                    end
                end
                S_W_EN: cnt_q <= '0;
                S_SETTLE: begin
                    if (state_d == S_R_LOCK) begin
                        streak_q <= '0;
                        round_q  <= '0;
                        sat_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_R_SAT: begin
                    if (ph_q) begin
                        cnt_q <= '0;
                        case (state_d)
                            S_IDLE: begin
                                locked_q <= 1'b1;
                                busy_q   <= 1'b0;
                            end
                            S_W_DIS: begin
                                if (sat_q) sat_seen_q <= 1'b1;
                                else if (round_q != ROUND_FULL) round_q <= round_q + 1'b1;
                            end
                            S_GAP: if (round_q != ROUND_FULL) round_q <= round_q + 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_GAP: cnt_q <= cnt_q + 1'b1;
                S_W_DIS: begin
                    if (ph_q) begin
                        if (state_d == S_W_SRST) begin
                            attempt_q <= attempt_q + 1'b1;
                        end else if (state_d == S_IDLE) begin
                            fail_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                S_ABORT_DIS: begin
                    if (ph_q) begin
                        fail_q       <= 1'b1;
                        sat_seen_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        abort_pend_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel      = sel_q;
    assign write    = write_q;
    assign address  = address_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign locked   = locked_q;
    assign fail     = fail_q;
    assign sat_seen = sat_seen_q;
    assign attempt  = attempt_q;

endmodule

// File: tb/tb_adpll_lock_seq.sv
// Directed bench for adpll_lock_seq with a register-slave model on the CPU port.
module tb_adpll_lock_seq;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [25:0] fcw_in;
    logic [1:0]  mode_in;
    logic        sel, write;
    logic [4:0]  address;
    logic [31:0] wdata;
    logic        ready = 1'b0;
    logic [31:0] rdata = '0;
    logic        busy, locked, fail, sat_seen;
    logic [1:0]  attempt;

    adpll_lock_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fcw_in(fcw_in), .mode_in(mode_in),
        .sel(sel), .write(write), .address(address), .wdata(wdata),
        .ready(ready), .rdata(rdata),
        .busy(busy), .locked(locked), .fail(fail), .sat_seen(sat_seen),
        .attempt(attempt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour knobs: lock_mode 0 = always 1, 1 = always 0, 2 = glitch pattern.
    int         lock_mode = 0;
    int         sat_at = 0;
    int         lk_n = 0, st_n = 0;
    int         lk_base = 0, st_base = 0;
    int         wbase = 0;
    logic [6:0] glitch_pat = 7'b1111011;
    int         wa[$];
    logic [31:0] wd[$];

    function automatic logic lock_val(input int i);
        if (lock_mode == 0) return 1'b1;
        if (lock_mode == 1) return 1'b0;
        if (i < 7) return glitch_pat[i];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        ready <= sel;
        rdata <= '0;
        if (sel && !ready && !write) begin
            if (address == 5'd20) begin
                rdata <= {31'd0, lock_val(lk_n - lk_base)};
                lk_n = lk_n + 1;
            end else if (address == 5'd21) begin
                st_n = st_n + 1;
                rdata <= {31'd0, ((st_n - st_base) == sat_at)};
            end
        end
    end

    always @(negedge clk) begin
        if (sel && ready && write) begin
            wa.push_back(int'(address));
            wd.push_back(wdata);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int count_w(input int a, input logic [31:0] d);
        int c = 0;
        for (int i = wbase; i < wa.size(); i++)
            if (wa[i] == a && wd[i] == d) c++;
        return c;
    endfunction

    task automatic begin_test();
        wbase   = wa.size();
        lk_base = lk_n;
        st_base = st_n;
    endtask

    // Leaves the caller at the falling edge inside cycle 1 (start sampled at cycle 0).
    task automatic do_start(input logic [25:0] f, input logic [1:0] m);
        @(negedge clk);
        fcw_in  = f;
        mode_in = m;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int cyc);
        cyc = 1;
        while (busy && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done"}, busy, 1'b0);
    endtask

    int cyc;
    int n;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; fcw_in = '0; mode_in = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_flags", {sel, write, busy, locked, fail, sat_seen, attempt}, 8'd0);
        check_eq("rst_bus", {address, wdata}, 37'd0);
        rst = 1'b0;

        // Immediate lock with the default channel word
        lock_mode = 0; sat_at = 0;
        begin_test();
        do_start(26'h2620000, 2'd2);
        check_eq("lock_first_sel", {sel, write, address}, {1'b1, 1'b1, 5'd0});
        wait_done("lock", 2000, cyc);
        check_eq("lock_cycle", cyc, 341);
        check_eq("lock_status", {locked, fail, sat_seen, attempt}, 5'b10000);
        check_eq("lock_nwrites", wa.size() - wbase, 4);
        check_eq("lock_w0", {wa[wbase] , wd[wbase]},   {32'd0, 32'd1});
        check_eq("lock_w1", {wa[wbase+1], wd[wbase+1]}, {32'd1, 32'h2620000});
        check_eq("lock_w2", {wa[wbase+2], wd[wbase+2]}, {32'd2, 32'd2});
        check_eq("lock_w3", {wa[wbase+3], wd[wbase+3]}, {32'd3, 32'd1});
        check_eq("lock_reads", lk_n - lk_base, 4);

        // Abort while idle must not disturb status or start a transaction
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("idle_abort", {sel, busy, locked, fail}, 4'b0010);

        // Lock glitch: streak restarts on the third read
        lock_mode = 2; sat_at = 0;
        begin_test();
        do_start(26'h1234567, 2'd1);
        wait_done("glitch", 2000, cyc);
        check_eq("glitch_cycle", cyc, 407);
        check_eq("glitch_reads", lk_n - lk_base, 7);
        check_eq("glitch_status", {locked, fail, attempt}, 4'b1000);

        // Timeout on every attempt, with two retries
        lock_mode = 1; sat_at = 0;
        begin_test();
        do_start(26'h0ABCDEF, 2'd3);
        wait_done("tmo", 6000, cyc);
        check_eq("tmo_status", {locked, fail, sat_seen, attempt}, 5'b01010);
        check_eq("tmo_srst", count_w(0, 32'd1), 3);
        check_eq("tmo_dis", count_w(3, 32'd0), 3);
        check_eq("tmo_fcw", count_w(1, 32'h0ABCDEF), 3);
        check_eq("tmo_nwrites", wa.size() - wbase, 15);
        check_eq("tmo_reads", lk_n - lk_base, 192);

        // Saturation on round 2 ends without retry even while lock reads 1
        lock_mode = 0; sat_at = 2;
        begin_test();
        do_start(26'h2620000, 2'd0);
        wait_done("sat", 2000, cyc);
        check_eq("sat_status", {locked, fail, sat_seen, attempt}, 5'b01100);
        check_eq("sat_nwrites", wa.size() - wbase, 5);
        check_eq("sat_last", {wa[wa.size()-1], wd[wd.size()-1]}, {32'd3, 32'd0});
        check_eq("sat_reads", lk_n - lk_base, 2);

        // Abort while settling
        lock_mode = 1; sat_at = 0;
        begin_test();
        do_start(26'h2620000, 2'd2);
        repeat (48) @(negedge clk);
        abort = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            abort = 1'b0;
            n++;
        end while (busy && n < 20);
        check_eq("abs_cycles", n, 4);
        check_eq("abs_status", {busy, locked, fail, sat_seen, attempt}, 6'b001000);
        check_eq("abs_nwrites", wa.size() - wbase, 5);
        check_eq("abs_last", {wa[wa.size()-1], wd[wd.size()-1]}, {32'd3, 32'd0});

        // Abort raised in the cycle the FCW write first drives sel
        begin_test();
        do_start(26'h2620000, 2'd2);
        repeat (3) @(negedge clk);
        check_eq("abf_sel", {sel, address}, {1'b1, 5'd1});
        abort = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            abort = 1'b0;
            n++;
        end while (busy && n < 20);
        check_eq("abf_cycles", n, 6);
        check_eq("abf_status", {busy, fail, sat_seen}, 3'b010);
        check_eq("abf_nwrites", wa.size() - wbase, 3);
        check_eq("abf_w1", {wa[wbase+1], wd[wbase+1]}, {32'd1, 32'h2620000});
        check_eq("abf_w2", {wa[wbase+2], wd[wbase+2]}, {32'd3, 32'd0});

        // Reset while a lock read is on the bus
        lock_mode = 1;
        begin_test();
        do_start(26'h2620000, 2'd2);
        n = 0;
        while (!(sel && address == 5'd20) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("rrl_reached", {sel, address}, {1'b1, 5'd20});
        rst = 1'b1;
        @(negedge clk);
        check_eq("rrl_flags", {sel, write, busy, locked, fail, sat_seen, attempt}, 8'd0);
        check_eq("rrl_bus", {address, wdata}, 37'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rrl_nodis", count_w(3, 32'd0), 0);

        // Start while busy is ignored and the latched channel is kept
        lock_mode = 0; sat_at = 0;
        begin_test();
        do_start(26'h1111111, 2'd1);
        @(negedge clk);
        fcw_in = 26'h2222222;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("sbusy", 2000, cyc);
        check_eq("sbusy_fcw", {wa[wbase+1], wd[wbase+1]}, {32'd1, 32'h1111111});
        check_eq("sbusy_nwrites", wa.size() - wbase, 4);
        check_eq("sbusy_status", {locked, fail, attempt}, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adpll_lock_seq.md
# adpll_lock_seq

Hardware bring-up sequencer for the ADPLL register block. On a single `start` pulse it soft-resets the ADPLL, programs channel FCW and mode, enables the loop, then polls the lock and saturation status registers until lock is confirmed, saturation is reported, or a timeout expires. It retries a bounded number of times before failing. It sits between the radio MAC/channel-hop logic and the ADPLL CPU port, acting as a bus master on that port in place of the CPU.

## Interface
- `ADDR_W`, 5: register address width.
- `FCWW`, 26: FCW width.
- `A_SOFT_RST`, `A_FCW`, `A_MODE`, `A_EN`, `A_LOCK`, `A_SAT`, 0/1/2/3/20/21: register addresses.
- `SETTLE`, 256: cycles to wait after enable before the first poll.
- `POLL_GAP`, 16: idle cycles between poll rounds.
- `LOCK_CNT`, 4: consecutive lock=1 reads required.
- `TIMEOUT`, 64: maximum poll rounds per attempt.
- `RETRIES`, 2: extra attempts after the first.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; ignored unless `busy`=0.
- `abort` in 1: cancel the sequence and disable the ADPLL.
- `fcw_in` in FCWW: channel FCW, latched on `start`.
- `mode_in` in 2: adpll_mode, latched on `start`.
- `sel` out 1, `write` out 1, `address` out ADDR_W, `wdata` out 32: master side of the ADPLL CPU port.
- `ready` in 1, `rdata` in 32: slave response; `ready` is `sel` registered by one cycle.
- `busy` out 1: sequence in progress.
- `locked` out 1: last sequence ended in lock.
- `fail` out 1: last sequence ended in timeout or saturation.
- `sat_seen` out 1: failure cause was saturation.
- `attempt` out 2: attempt index of the current or last sequence.

## Operation
- States: IDLE, W_SRST, W_FCW, W_MODE, W_EN, SETTLE, R_LOCK, R_SAT, GAP, W_DIS, ABORT_DIS.
- Bus transaction:
  - Drive `sel`=1 with `address`, `write` and `wdata` held stable until `ready`=1 is sampled. `rdata` is captured in that same cycle.
  - `sel` drops in the next cycle. The cycle after that is forced idle, so a transaction always takes exactly 3 cycles.
  - `wdata` is 0 on reads.
- Start: IDLE with `start`=1 does the following:
  - Latch `fcw_in` and `mode_in`.
  - Clear `locked`, `fail`, `sat_seen` and `attempt`.
  - Set `busy`=1 and go to W_SRST.
- Write sequence:
  - W_SRST writes 1 to A_SOFT_RST. The slave self-clears it.
  - W_FCW writes the FCW, zero-extended to 32 bits.
  - W_MODE writes the mode.
  - W_EN writes 1.
  - Then go to SETTLE.
- SETTLE waits SETTLE cycles, clears the lock streak counter and the round counter, then goes to R_LOCK.
- Poll round (R_LOCK, then R_SAT):
  - R_LOCK reads A_LOCK. `rdata[0]`=1 increments the streak; `rdata[0]`=0 clears it.
  - R_SAT reads A_SAT.
  - Round resolution, evaluated in this priority order:
    1. sat=1: fail with `sat_seen`=1 and go to W_DIS. No retry.
    2. streak=LOCK_CNT: `locked`=1, `busy`=0, go to IDLE. The ADPLL stays enabled.
    3. Otherwise increment the round counter. If it reaches TIMEOUT, go to W_DIS. Else go to GAP, wait POLL_GAP cycles, then R_LOCK.
- W_DIS writes 0 to A_EN. Then:
  - If the cause was a timeout and `attempt`<RETRIES: increment `attempt` and go to W_SRST.
  - Otherwise: `fail`=1, `busy`=0, go to IDLE.
- Abort:
  - `abort`=1 in any non-IDLE state lets an in-flight transaction complete.
  - Then ABORT_DIS writes 0 to A_EN and the block returns to IDLE with `fail`=1, `sat_seen`=0.
  - `abort` in IDLE is ignored.
  - `abort` and `start` in the same IDLE cycle: `start` wins.
- `start` while `busy`=1 is ignored. Status outputs hold until the next accepted `start`.
- Counters saturate and never wrap. The streak counter is log2(LOCK_CNT)+1 bits; the round counter is log2(TIMEOUT)+1 bits.

## Timing
- Reset values, with `rst`=1 sampled on `clk`:
  - State is IDLE.
  - `sel`, `write`, `busy`, `locked`, `fail` and `sat_seen` are all 0.
  - `address`, `wdata` and `attempt` are 0.
  - Reset mid-transaction drops `sel` in the next cycle and performs no disable write.
- Latency:
  - `start` at cycle 0 gives the first `sel`=1 at cycle 1.
  - The four configuration writes complete by cycle 12.
  - SETTLE runs from cycle 13 to cycle 12+SETTLE.
- A poll round lasts 6 cycles plus POLL_GAP.
- Best-case lock: `locked` rises at cycle 12 + SETTLE + 6·LOCK_CNT + POLL_GAP·(LOCK_CNT−1) + 1.
- Outputs are registered. `busy` falls in the same cycle `locked` or `fail` rises.

## Test plan
- Lock immediately. Slave model returns lock=1 and sat=0 from the first poll, with defaults → write sequence is addr 0/1/2/3 with data 1/0x2620000/mode/1. `locked`=1 after 4 rounds, `fail`=0, `attempt`=0.
- Lock glitch. Lock pattern 1,1,0,1,1,1,1 → streak resets on the 0; `locked` asserts after round 7.
- Timeout with retries. Lock is always 0 → 3 attempts, each ending with an A_EN=0 write. Final state is `fail`=1, `sat_seen`=0, `attempt`=2, and exactly 3 W_SRST writes occur.
- Saturation. sat=1 on round 2 → one A_EN=0 write, `fail`=1, `sat_seen`=1, no retry.
- Abort during SETTLE, and separately with `abort` asserted in the same cycle `sel` rises on W_FCW → the current write completes, then A_EN=0 is written, then `fail`=1 and `busy`=0.
- Reset and start edge cases:
  - `rst` during R_LOCK → next cycle has `sel`=0 and all outputs at reset values.
  - `start` while busy → ignored, latched FCW unchanged.
